uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 79 +++++++
 tb/tb_uart_tx_feeder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that launches queued bytes into a UART transmitter one handshake at a time.
module uart_tx_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     tx_active,
  input  logic                     tx_done,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_ACT, S_WAIT_DONE, S_GAP} state_t;
  state_t          r_state, w_next;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_level;
  logic            r_overflow;
  logic [7:0]      r_tx_data;
  logic [1:0]      r_act_cnt;
  logic            w_pop, w_push, w_drop, w_launch;
  assign full     = r_level == (AW+1)'(DEPTH);
  assign empty    = r_level == '0;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign tx_data  = r_tx_data;
  assign busy     = r_state != S_IDLE;
  // a flush landing between the launch decision and S_LAUNCH leaves nothing to pop, so the launch is abandoned
  assign w_pop    = r_state == S_LAUNCH && !empty;
  assign tx_start = w_pop;
  assign w_push   = wr_en && !flush && (!full || w_pop);
  assign w_drop   = wr_en && full && !w_pop;
  assign w_launch = r_state == S_IDLE && !empty && !tx_active && !tx_done;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = w_launch ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    w_next = w_pop ? S_WAIT_ACT : S_IDLE;
      S_WAIT_ACT:  w_next = (tx_active || r_act_cnt == 2'd3) ? S_WAIT_DONE : S_WAIT_ACT;
      S_WAIT_DONE: w_next = tx_done ? S_GAP : S_WAIT_DONE;
      S_GAP:       w_next = (!tx_done && !tx_active) ? S_IDLE : S_GAP;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst && w_push) r_mem[r_wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_act_cnt  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state   <= w_next;
      r_act_cnt <= r_state == S_WAIT_ACT ? r_act_cnt + 2'd1 : 2'd0;
      if (w_drop) r_overflow <= 1'b1;
      if (w_launch) r_tx_data <= r_mem[r_rd_ptr];
      if (flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: queue-model scoreboard plus handshake protocol checks against a behavioural UART transmitter.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  logic       clk = 0, rst = 1, wr_en = 0, flush = 0, stall = 0, m_active = 0, m_done = 0, tx_busy = 0;
  logic [7:0] wr_data = 0;
  logic       tx_active, tx_done, full, empty, overflow, tx_start, busy;
  logic [4:0] level;
  logic [7:0] tx_data;
  assign tx_active = stall | m_active;
  assign tx_done   = m_done;
  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .tx_active(tx_active), .tx_done(tx_done), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .tx_start(tx_start), .tx_data(tx_data), .busy(busy)
  );
  always #5 clk = ~clk;
  int         n_cmp = 0, n_bad = 0, n_start = 0, elig_cnt = 0, sz0 = 0;
  logic [7:0] exp_q [$];
  bit         m_ovf = 0, inflight = 0, seen_done = 0, prev_elig = 0, elig = 0, is_full = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("level", level, exp_q.size());
    chk("full", full, exp_q.size() == DEPTH);
    chk("empty", empty, exp_q.size() == 0);
    chk("overflow", overflow, m_ovf);
    if (rst) begin
      exp_q.delete();
      m_ovf = 0; inflight = 0; seen_done = 0; prev_elig = 0; elig_cnt = 0;
    end else begin
      sz0 = exp_q.size();
      is_full = sz0 == DEPTH;
      if (tx_start) begin
        n_start++;
        chk("launch_allowed", prev_elig, 1);
        chk("launch_nonempty", sz0 > 0, 1);
        if (sz0 > 0) chk("tx_data", tx_data, exp_q.pop_front());
        inflight = 1; seen_done = 0; elig_cnt = 0;
      end else if (inflight) begin
        if (tx_done) seen_done = 1;
        else if (seen_done) inflight = 0;
      end
      if (inflight) chk("busy_inflight", busy, 1);
      if (flush) begin
        if (wr_en && is_full && !tx_start) m_ovf = 1;
        exp_q.delete();
      end else if (wr_en) begin
        if (!is_full || tx_start) exp_q.push_back(wr_data);
        else m_ovf = 1;
      end
      elig = !inflight && !tx_active && !tx_done && !flush && sz0 > 0;
      if (!tx_start) begin
        elig_cnt = elig ? elig_cnt + 1 : 0;
        if (elig) chk("launch_latency", elig_cnt <= 2, 1);
      end
      prev_elig = elig;
    end
  end
  task automatic run_tx();
    int d, l, h;
    bit noact;
    d = $urandom_range(1, 3); l = $urandom_range(2, 6); h = $urandom_range(1, 2);
    noact = $urandom_range(0, 7) == 0;
    tx_busy = 1;
    if (noact) begin
      repeat (6) @(posedge clk);
      #1 m_done = 1;
    end else begin
      repeat (d) @(posedge clk);
      #1 m_active = 1;
      repeat (l) @(posedge clk);
      #1 m_active = 0;
      m_done = 1;
    end
    repeat (h) @(posedge clk);
    #1 m_done = 0;
    tx_busy = 0;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (tx_start) run_tx();
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic write_byte(input logic [7:0] d);
    wr_en = 1; wr_data = d;
    cyc();
    wr_en = 0;
  endtask
  task automatic do_reset();
    rst = 1; wr_en = 1; flush = 1; wr_data = 8'hE7;
    cyc();
    rst = 0; wr_en = 0; flush = 0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || busy || tx_busy) && k < 3000) begin
      cyc();
      k++;
    end
    chk("drain_timeout", k < 3000, 1);
  endtask
  initial begin
    int s0, k;
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int s0, k;
    rst = 1; wr_en = 1; flush = 1; wr_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    rst = 0; wr_en = 0; flush = 0;
    s0 = n_start;
    write_byte(8'h55);
    wait_idle();
    chk("single_starts", n_start - s0, 1);
    chk("single_level", level, 0);
    stall = 1;
    s0 = n_start;
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    chk("burst_full", full, 1);
    chk("burst_ovf", overflow, 0);
    stall = 0;
    wait_idle();
    chk("burst_starts", n_start - s0, 16);
    stall = 1;
    s0 = n_start;
    for (int i = 0; i < 16; i++) write_byte(8'($urandom_range(0, 169)));
    write_byte(8'hAA);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 16);
    stall = 0;
    wait_idle();
    chk("ovf_starts", n_start - s0, 16);
    do_reset();
    chk("rst_clears_ovf", overflow, 0);
    stall = 1;
    for (int i = 0; i < 16; i++) write_byte(8'($urandom));
    stall = 0;
    k = 0;
    while (!tx_start && k < 20) begin
      cyc();
      k++;
    end
    chk("pushpop_launch_seen", k < 20, 1);
    write_byte(8'h3C);
    chk("pushpop_level", level, 16);
    chk("pushpop_ovf", overflow, 0);
    wait_idle();
    s0 = n_start;
    for (int i = 0; i < 8; i++) write_byte(8'($urandom));
    k = 0;
    while (n_start - s0 < 3 && k < 500) begin
      cyc();
      k++;
    end
    chk("flush_third_seen", k < 500, 1);
    cyc();
    flush = 1;
    cyc();
    flush = 0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    wait_idle();
    chk("flush_starts", n_start - s0, 3);
    s0 = n_start;
    for (int i = 0; i < 6; i++) write_byte(8'($urandom));
    k = 0;
    while (!(n_start > s0 && m_active) && k < 200) begin
      cyc();
      k++;
    end
    chk("midrst_active_seen", k < 200, 1);
    cyc();
    rst = 1; wr_en = 1; wr_data = 8'h77; flush = 1;
    cyc();
    rst = 0; wr_en = 0; flush = 0;
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_start", tx_start, 0);
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
    wait_idle();
    for (int i = 0; i < 600; i++) begin
      wr_en = $urandom_range(0, 99) < 45;
      wr_data = 8'($urandom);
      flush = $urandom_range(0, 99) < 2;
      cyc();
    end
    wr_en = 0; flush = 0;
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
